llc_request_arbiter: RTL and testbench
======================================

// Module: llc_request_arbiter
// PURPOSE
//  N-channel arbiter merging per-client LLC line requests (L1I fetch, L1D fill/writeback, ...) onto one lc_* port.
//  Round-robin request grant; in-order read-response routing back to the issuing channel via an owner FIFO.
//  Sits in ozone top between the client caches and the last-level-cache interface.
// PARAMETERS
//  N_CH            2    number of client channels (>=1); ID_W = (N_CH>1) ? $clog2(N_CH) : 1
//  ADDR_W          64   line address width
//  LINE_W          512  line data width (8*B)
//  MAX_OUTSTANDING 4    max issued-but-unanswered reads (owner FIFO depth, power of 2)
// PORTS
//  clk_in        in  1               clock
//  rst_N_in      in  1               async active-low reset
//  cl_valid_in   in  N_CH            client request valid
//  cl_ready_out  out N_CH            client request accepted (one-hot or 0)
//  cl_addr_in    in  N_CH*ADDR_W     client request address (packed [N_CH-1:0][ADDR_W-1:0])
//  cl_value_in   in  N_CH*LINE_W     client write data
//  cl_we_in      in  N_CH            client write enable (1=write, 0=read)
//  cl_valid_out  out N_CH            response valid to owning client (one-hot or 0)
//  cl_ready_in   in  N_CH            client response ready
//  cl_addr_out   out ADDR_W          response address (shared, qualified by cl_valid_out)
//  cl_value_out  out LINE_W          response data (shared)
//  lc_valid_out  out 1               LLC request valid
//  lc_ready_in   in  1               LLC request ready
//  lc_addr_out   out ADDR_W          LLC request address
//  lc_value_out  out LINE_W          LLC write data
//  lc_we_out     out 1               LLC write enable
//  lc_valid_in   in  1               LLC response valid
//  lc_ready_out  out 1               arbiter can accept LLC response
//  lc_addr_in    in  ADDR_W          LLC response address
//  lc_value_in   in  LINE_W          LLC response data
//  orphan_err_out out 1              sticky: LLC response arrived with owner FIFO empty
// BEHAVIOUR
//  Reset (async, rst_N_in=0): all outputs 0, request/response regs invalid, owner FIFO empty, rr_ptr=0, orphan_err_out=0.
//  Request reg: holds {id,addr,value,we}; lc_* outputs driven directly from it; lc_valid_out = req_vld.
//  req_fire = lc_valid_out & lc_ready_in. req_free = !req_vld | req_fire.
//  Eligible ch i: cl_valid_in[i] & (cl_we_in[i] | !fifo_full_eff), where fifo_full_eff counts entries pending push.
//  Grant: first eligible ch scanning rr_ptr, rr_ptr+1, ... mod N_CH; issued only when req_free.
//  On grant to g: cl_ready_out[g]=1 same cycle (combinational), req reg loads next edge, rr_ptr <= (g+1) mod N_CH.
//  No eligible ch or !req_free: cl_ready_out=0, rr_ptr unchanged. Back-to-back: 1 req/cycle while lc_ready_in=1.
//  Request latency: cl accept at edge k -> lc_valid_out high from k (registered), 1-cycle min.
//  Read req_fire: push req id into owner FIFO. Write req_fire: posted, no push (see CONFIGURATION).
//  Outstanding count increments on read issue-to-reg (reservation) so FIFO can never overflow; decrements on pop.
//  Response reg: lc_ready_out = !rsp_vld | rsp_fire; rsp_fire = |(cl_valid_out & cl_ready_in).
//  lc_valid_in & lc_ready_out & FIFO non-empty: capture addr/value, pop head id -> cl_valid_out[id]=1 next cycle.
//  lc_valid_in & lc_ready_out & FIFO empty: response dropped, orphan_err_out <= 1 (cleared only by reset).
//  Simultaneous push and pop on same edge: both take effect, count unchanged. Pointers wrap mod MAX_OUTSTANDING.
//  Responses returned strictly in LLC order; client holding cl_ready_in=0 stalls all responses (head-of-line).
//  Payload (addr/value/we/id) in req reg must not change while req_vld & !lc_ready_in.
// CONFIGURATION
//  OZONE_LLC_ARB_WRITE_ACK_EN defined: writes also push owner id and reserve a slot; LLC returns an ack
//   response (lc_valid_in, addr valid, value don't-care) routed to writer like a read; writes blocked when FIFO full.
//  Undefined: writes posted, never enter FIFO, never blocked by fifo_full; any ack counts as orphan if FIFO empty.
// TESTING
//  Reset mid-transfer: assert rst_N_in with req_vld=1, 2 entries queued -> all outputs 0 same cycle, FIFO empty after release.
//  Fairness: N_CH=2, both cl_valid_in=1 reads, lc_ready_in=1 -> grants alternate ch0,ch1,ch0,ch1; rr_ptr toggles.
//  Routing: ch1 reads 0x1000, ch0 reads 0x2000; LLC returns in order -> cl_valid_out=2'b10 addr 0x1000, then 2'b01 addr 0x2000.
//  Full: MAX_OUTSTANDING=4, 4 reads issued, no responses -> 5th read cl_ready_out=0; one response -> 5th accepted next cycle.
//  Backpressure: lc_ready_in=0 for 3 cycles -> lc_addr_out/value/we stable, cl_ready_out=0; release -> single fire.
//  Orphan: lc_valid_in=1 with FIFO empty -> no cl_valid_out, orphan_err_out=1 until reset; write w/o _EN -> no FIFO push.

Source files
------------

// File: rtl/llc_request_arbiter_if.sv
// Bundle of the client-side and LLC-side handshake buses of llc_request_arbiter.
// Modport "slave" is the arbiter's view. Modport "master" is the environment's view,
// covering both the clients and the LLC.
interface llc_request_arbiter_if #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 64,
    parameter int LINE_W = 512
);
    // client request side
    logic [N_CH-1:0]              cl_valid_in;
    logic [N_CH-1:0]              cl_ready_out;
    logic [N_CH-1:0][ADDR_W-1:0]  cl_addr_in;
    logic [N_CH-1:0][LINE_W-1:0]  cl_value_in;
    logic [N_CH-1:0]              cl_we_in;
    // client response side
    logic [N_CH-1:0]              cl_valid_out;
    logic [N_CH-1:0]              cl_ready_in;
    logic [ADDR_W-1:0]            cl_addr_out;
    logic [LINE_W-1:0]            cl_value_out;
    // LLC request side
    logic                         lc_valid_out;
    logic                         lc_ready_in;
    logic [ADDR_W-1:0]            lc_addr_out;
    logic [LINE_W-1:0]            lc_value_out;
    logic                         lc_we_out;
    // LLC response side
    logic                         lc_valid_in;
    logic                         lc_ready_out;
    logic [ADDR_W-1:0]            lc_addr_in;
    logic [LINE_W-1:0]            lc_value_in;

    modport slave (
        input  cl_valid_in, cl_addr_in, cl_value_in, cl_we_in, cl_ready_in,
        input  lc_ready_in, lc_valid_in, lc_addr_in, lc_value_in,
        output cl_ready_out, cl_valid_out, cl_addr_out, cl_value_out,
        output lc_valid_out, lc_addr_out, lc_value_out, lc_we_out, lc_ready_out
    );

    modport master (
        output cl_valid_in, cl_addr_in, cl_value_in, cl_we_in, cl_ready_in,
        output lc_ready_in, lc_valid_in, lc_addr_in, lc_value_in,
        input  cl_ready_out, cl_valid_out, cl_addr_out, cl_value_out,
        input  lc_valid_out, lc_addr_out, lc_value_out, lc_we_out, lc_ready_out
    );
endinterface

// File: rtl/llc_request_arbiter.sv
// llc_request_arbiter: merges N_CH client line requests onto one LLC port.
// It grants requests round-robin through a one-entry request register.
// Read responses return in order: an owner FIFO of channel ids routes each one back to the client that issued it.
// Optional feature macro OZONE_LLC_ARB_WRITE_ACK_EN:
//   - defined: writes are also tracked in the owner FIFO and receive an ack response.
//   - undefined: writes are posted and never enter the FIFO.
module llc_request_arbiter #(
    parameter int N_CH            = 2,
    parameter int ADDR_W          = 64,
    parameter int LINE_W          = 512,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_N_in,
    llc_request_arbiter_if.slave  bus,
    output logic                  orphan_err_out
);
    localparam int ID_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // Returns 1 if a request of this kind needs a response routed back to its issuer.
    function automatic logic is_tracked(input logic we);
`ifdef OZONE_LLC_ARB_WRITE_ACK_EN
        is_tracked = we | ~we;
`else
        is_tracked = ~we;
`endif
    endfunction

    // Channel index base+off, wrapped modulo N_CH.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(N_CH)) begin
            sum = sum - 32'(N_CH);
        end else begin
            sum = sum;
        end
        rr_index = ID_W'(sum);
    endfunction

    // FIFO pointer increment, wrapping at MAX_OUTSTANDING.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // request register
    logic              req_vld_q,   req_vld_d;
    logic [ID_W-1:0]   req_id_q,    req_id_d;
    logic [ADDR_W-1:0] req_addr_q,  req_addr_d;
    logic [LINE_W-1:0] req_value_q, req_value_d;
    logic              req_we_q,    req_we_d;
    logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
    // outstanding reservations and owner FIFO
    logic [CNT_W-1:0]  out_cnt_q,   out_cnt_d;
    logic [ID_W-1:0]   fifo_mem_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  fifo_wr_q,   fifo_wr_d;
    logic [PTR_W-1:0]  fifo_rd_q,   fifo_rd_d;
    logic [CNT_W-1:0]  fifo_cnt_q,  fifo_cnt_d;
    // response register
    logic              rsp_vld_q,   rsp_vld_d;
    logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
    logic [ADDR_W-1:0] rsp_addr_q,  rsp_addr_d;
    logic [LINE_W-1:0] rsp_value_q, rsp_value_d;
    logic              orphan_q,    orphan_d;

    logic              req_fire_s, req_free_s, fifo_full_eff_s, req_load_s, reserve_s;
    logic              push_s, pop_s, fifo_empty_s, rsp_fire_s, lc_ready_s, rsp_take_s;
    logic [N_CH-1:0]   elig_s, grant_oh_s, rsp_oh_s;
    logic              grant_found_s;
    logic [ID_W-1:0]   grant_id_s;

    assign req_fire_s      = req_vld_q & bus.lc_ready_in;
    assign req_free_s      = ~req_vld_q | req_fire_s;
    assign fifo_full_eff_s = (out_cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty_s    = (fifo_cnt_q == CNT_W'(0));
    assign push_s          = req_fire_s & is_tracked(req_we_q);
    assign rsp_fire_s      = |(rsp_oh_s & bus.cl_ready_in);
    assign lc_ready_s      = ~rsp_vld_q | rsp_fire_s;
    assign rsp_take_s      = bus.lc_valid_in & lc_ready_s;
    assign pop_s           = rsp_take_s & ~fifo_empty_s;

    // Eligibility: writes bypass the full check unless they are tracked.
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            elig_s[i] = bus.cl_valid_in[i] & (~is_tracked(bus.cl_we_in[i]) | ~fifo_full_eff_s);
        end
    end

    // Round-robin search for the first eligible channel starting at rr_ptr.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!grant_found_s && elig_s[rr_index(rr_ptr_q, k)]) begin
                grant_found_s = 1'b1;
                grant_id_s    = rr_index(rr_ptr_q, k);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    assign req_load_s = req_free_s & grant_found_s;
    assign reserve_s  = req_load_s & is_tracked(bus.cl_we_in[grant_id_s]);

    // One-hot decode of the grant and of the response owner.
    always_comb begin
        grant_oh_s = '0;
        rsp_oh_s   = '0;
        for (int i = 0; i < N_CH; i++) begin
            grant_oh_s[i] = req_load_s & (grant_id_s == ID_W'(i));
            rsp_oh_s[i]   = rsp_vld_q & (rsp_id_q == ID_W'(i));
        end
    end

    // Request register, rr pointer and reservation counter next-state.
    always_comb begin
        req_vld_d   = req_vld_q;
        req_id_d    = req_id_q;
        req_addr_d  = req_addr_q;
        req_value_d = req_value_q;
        req_we_d    = req_we_q;
        rr_ptr_d    = rr_ptr_q;
        out_cnt_d   = out_cnt_q;
        if (req_load_s) begin
            req_vld_d   = 1'b1;
            req_id_d    = grant_id_s;
            req_addr_d  = bus.cl_addr_in[grant_id_s];
            req_value_d = bus.cl_value_in[grant_id_s];
            req_we_d    = bus.cl_we_in[grant_id_s];
            rr_ptr_d    = rr_index(grant_id_s, 1);
        end else if (req_fire_s) begin
            req_vld_d   = 1'b0;
        end else begin
            req_vld_d   = req_vld_q;
        end
        case ({reserve_s, pop_s})
            2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    // Owner FIFO pointers/count and response register next-state.
    always_comb begin
        fifo_wr_d   = push_s ? ptr_inc(fifo_wr_q) : fifo_wr_q;
        fifo_rd_d   = pop_s  ? ptr_inc(fifo_rd_q) : fifo_rd_q;
        fifo_cnt_d  = fifo_cnt_q;
        rsp_vld_d   = rsp_vld_q;
        rsp_id_d    = rsp_id_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_value_d = rsp_value_q;
        orphan_d    = orphan_q | (rsp_take_s & fifo_empty_s);
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        if (pop_s) begin
            rsp_vld_d   = 1'b1;
            rsp_id_d    = fifo_mem_q[fifo_rd_q];
            rsp_addr_d  = bus.lc_addr_in;
            rsp_value_d = bus.lc_value_in;
        end else if (rsp_fire_s) begin
            rsp_vld_d   = 1'b0;
        end else begin
            rsp_vld_d   = rsp_vld_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            req_vld_q   <= 1'b0;
            req_id_q    <= '0;
            req_addr_q  <= '0;
            req_value_q <= '0;
            req_we_q    <= 1'b0;
            rr_ptr_q    <= '0;
            out_cnt_q   <= '0;
            fifo_wr_q   <= '0;
            fifo_rd_q   <= '0;
            fifo_cnt_q  <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_id_q    <= '0;
            rsp_addr_q  <= '0;
            rsp_value_q <= '0;
            orphan_q    <= 1'b0;
        end else begin
            req_vld_q   <= req_vld_d;
            req_id_q    <= req_id_d;
            req_addr_q  <= req_addr_d;
            req_value_q <= req_value_d;
            req_we_q    <= req_we_d;
            rr_ptr_q    <= rr_ptr_d;
            out_cnt_q   <= out_cnt_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_cnt_q  <= fifo_cnt_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_id_q    <= rsp_id_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_value_q <= rsp_value_d;
            orphan_q    <= orphan_d;
        end
    end

    // Owner FIFO storage: the owning channel id is written when a tracked request fires.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else if (push_s) begin
            fifo_mem_q[fifo_wr_q] <= req_id_q;
        end else begin
            fifo_mem_q[fifo_wr_q] <= fifo_mem_q[fifo_wr_q];
        end
    end

    // Ready outputs are combinational; they are held low while reset is asserted.
    assign bus.cl_ready_out = rst_N_in ? grant_oh_s : '0;
    assign bus.lc_ready_out = rst_N_in & lc_ready_s;
    assign bus.lc_valid_out = req_vld_q;
    assign bus.lc_addr_out  = req_addr_q;
    assign bus.lc_value_out = req_value_q;
    assign bus.lc_we_out    = req_we_q;
    assign bus.cl_valid_out = rsp_oh_s;
    assign bus.cl_addr_out  = rsp_addr_q;
    assign bus.cl_value_out = rsp_value_q;
    assign orphan_err_out   = orphan_q;
endmodule

// File: tb/tb_llc_request_arbiter.sv
// Testbench for llc_request_arbiter.
// A queue-based reference model predicts grants, readies and response routing.
// It pushes expected LLC requests and client responses into scoreboards.
// A separate monitor pops and compares entries whenever the DUT fires a transfer.
module tb_llc_request_arbiter;
    localparam int N_CH   = 2;
    localparam int ADDR_W = 64;
    localparam int LINE_W = 512;
    localparam int MAXO   = 4;

    typedef struct {
        int                ch;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] value;
        logic              we;
    } item_t;

    logic clk = 1'b0;
    logic rst_N_in;
    logic orphan_err_out;
    int   checks = 0;
    int   errors = 0;

    llc_request_arbiter_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    llc_request_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_in         (clk),
        .rst_N_in       (rst_N_in),
        .bus            (bus),
        .orphan_err_out (orphan_err_out)
    );

    always #5 clk = ~clk;

    item_t             exp_lc_q[$];
    item_t             exp_cl_q[$];
    int                owner_q[$];
    logic [ADDR_W-1:0] llc_pend[$];

    // model state
    int    rr_m       = 0;
    bit    slot_full_m = 1'b0;
    item_t slot_m;
    bit    rsp_full_m = 1'b0;
    item_t rsp_m;
    bit    orphan_m   = 1'b0;

    function automatic bit tracked(input logic we);
`ifdef OZONE_LLC_ARB_WRITE_ACK_EN
        return 1'b1;
`else
        return !we;
`endif
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: checks the handshake outputs, then advances one clock of abstract state.
    always @(negedge clk) begin
        bit                busy_tr, full, fire, free, found, rsp_fire, lc_rdy;
        int                reserved, g, c;
        logic [N_CH-1:0]   exp_rdy, exp_vout;
        item_t             it;
        if (!rst_N_in) begin
            chk("rst_zero", LINE_W'({|bus.cl_ready_out, |bus.cl_valid_out, |bus.cl_addr_out, |bus.cl_value_out,
                                     bus.lc_valid_out, |bus.lc_addr_out, |bus.lc_value_out, bus.lc_we_out,
                                     bus.lc_ready_out, orphan_err_out}), '0);
            rr_m = 0; slot_full_m = 0; rsp_full_m = 0; orphan_m = 0;
            owner_q.delete(); exp_lc_q.delete(); exp_cl_q.delete();
        end else begin
            busy_tr  = slot_full_m && tracked(slot_m.we);
            reserved = owner_q.size() + (busy_tr ? 1 : 0);
            full     = reserved >= MAXO;
            fire     = slot_full_m && bus.lc_ready_in;
            free     = !slot_full_m || fire;
            found    = 0; g = 0;
            for (int k = 0; k < N_CH; k++) begin
                c = (rr_m + k) % N_CH;
                if (!found && bus.cl_valid_in[c] && (!tracked(bus.cl_we_in[c]) || !full)) begin
                    found = 1; g = c;
                end
            end
            exp_rdy = '0;
            if (free && found) exp_rdy[g] = 1'b1;
            exp_vout = '0;
            if (rsp_full_m) exp_vout[rsp_m.ch] = 1'b1;
            rsp_fire = rsp_full_m && bus.cl_ready_in[rsp_m.ch];
            lc_rdy   = !rsp_full_m || rsp_fire;

            chk("cl_ready_out", LINE_W'(bus.cl_ready_out), LINE_W'(exp_rdy));
            chk("lc_valid_out", LINE_W'(bus.lc_valid_out), LINE_W'(slot_full_m));
            chk("cl_valid_out", LINE_W'(bus.cl_valid_out), LINE_W'(exp_vout));
            chk("lc_ready_out", LINE_W'(bus.lc_ready_out), LINE_W'(lc_rdy));
            chk("orphan_err",   LINE_W'(orphan_err_out),   LINE_W'(orphan_m));
            if (slot_full_m) begin
                chk("lc_addr_hold", LINE_W'(bus.lc_addr_out), LINE_W'(slot_m.addr));
                chk("lc_we_hold",   LINE_W'(bus.lc_we_out),   LINE_W'(slot_m.we));
            end

            if (rsp_fire) rsp_full_m = 0;
            if (bus.lc_valid_in && lc_rdy) begin
                if (owner_q.size() > 0) begin
                    rsp_m.ch    = owner_q.pop_front();
                    rsp_m.addr  = bus.lc_addr_in;
                    rsp_m.value = bus.lc_value_in;
                    rsp_m.we    = 1'b0;
                    rsp_full_m  = 1;
                    exp_cl_q.push_back(rsp_m);
                end else begin
                    orphan_m = 1;
                end
            end
            if (fire) begin
                if (tracked(slot_m.we)) owner_q.push_back(slot_m.ch);
                slot_full_m = 0;
            end
            if (free && found) begin
                it.ch = g; it.addr = bus.cl_addr_in[g]; it.value = bus.cl_value_in[g]; it.we = bus.cl_we_in[g];
                slot_m = it; slot_full_m = 1;
                exp_lc_q.push_back(it);
                rr_m = (g + 1) % N_CH;
            end
        end
    end

    // Monitor: pops the scoreboards whenever the DUT completes an LLC request or a client response.
    always @(negedge clk) begin
        item_t           e;
        logic [N_CH-1:0] oh;
        if (rst_N_in) begin
            if (bus.lc_valid_out && bus.lc_ready_in) begin
                if (exp_lc_q.size() == 0) begin
                    chk("lc_unexpected", LINE_W'(1), LINE_W'(0));
                end else begin
                    e = exp_lc_q.pop_front();
                    chk("lc_addr",  LINE_W'(bus.lc_addr_out), LINE_W'(e.addr));
                    chk("lc_value", bus.lc_value_out, e.value);
                    chk("lc_we",    LINE_W'(bus.lc_we_out), LINE_W'(e.we));
                end
            end
            if ((bus.cl_valid_out & bus.cl_ready_in) != '0) begin
                if (exp_cl_q.size() == 0) begin
                    chk("cl_unexpected", LINE_W'(1), LINE_W'(0));
                end else begin
                    e  = exp_cl_q.pop_front();
                    oh = '0; oh[e.ch] = 1'b1;
                    chk("cl_route", LINE_W'(bus.cl_valid_out), LINE_W'(oh));
                    chk("cl_addr",  LINE_W'(bus.cl_addr_out), LINE_W'(e.addr));
                    chk("cl_value", bus.cl_value_out, e.value);
                end
            end
        end
    end

    // One clock: sample LLC handshakes at negedge, then return to just after the next posedge.
    task automatic cycle();
        logic              acc, fire, rst_s, fwe;
        logic [ADDR_W-1:0] fa;
        @(negedge clk);
        rst_s = rst_N_in;
        acc   = bus.lc_valid_in && bus.lc_ready_out;
        fire  = bus.lc_valid_out && bus.lc_ready_in;
        fa    = bus.lc_addr_out;
        fwe   = bus.lc_we_out;
        @(posedge clk);
        #1;
        if (!rst_s) begin
            llc_pend.delete();
        end else begin
            if (acc && llc_pend.size() > 0) void'(llc_pend.pop_front());
            if (fire && tracked(fwe)) llc_pend.push_back(fa);
        end
    endtask

    // LLC stub: offers the oldest pending response with probability pct.
    task automatic llc_drive(input int pct);
        bus.lc_value_in = rand_line();
        if (llc_pend.size() > 0 && $urandom_range(99) < pct) begin
            bus.lc_valid_in = 1'b1;
            bus.lc_addr_in  = llc_pend[0];
        end else begin
            bus.lc_valid_in = 1'b0;
            bus.lc_addr_in  = {$urandom(), $urandom()};
        end
    endtask

    task automatic clients(input logic [N_CH-1:0] vld, input logic [N_CH-1:0] we);
        bus.cl_valid_in = vld;
        bus.cl_we_in    = we;
        for (int c = 0; c < N_CH; c++) begin
            bus.cl_addr_in[c]  = {$urandom(), $urandom()};
            bus.cl_value_in[c] = rand_line();
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            clients('0, '0);
            bus.lc_ready_in = 1'b1;
            bus.cl_ready_in = '1;
            llc_drive(100);
            cycle();
        end
    endtask

    initial begin
        rst_N_in = 1'b0;
        bus.lc_ready_in = 1'b1;
        bus.cl_ready_in = '1;
        clients('1, '0);
        llc_drive(0);
        repeat (3) cycle();
        rst_N_in = 1'b1;

        // fairness: both channels reading, everything ready
        for (int i = 0; i < 12; i++) begin
            clients('1, '0); bus.lc_ready_in = 1'b1; bus.cl_ready_in = '1; llc_drive(100); cycle();
        end
        drain(10);

        // full: reads from ch0 with no responses, then a single response frees one slot
        for (int i = 0; i < 8; i++) begin
            clients(2'b01, '0); bus.lc_ready_in = 1'b1; bus.lc_valid_in = 1'b0; cycle();
        end
        clients(2'b01, '0); llc_drive(100); cycle();
        for (int i = 0; i < 3; i++) begin
            clients(2'b01, '0); bus.lc_valid_in = 1'b0; cycle();
        end
        drain(15);

        // backpressure: LLC not ready for several cycles, then a single fire
        for (int i = 0; i < 4; i++) begin
            clients('1, 2'b10); bus.lc_ready_in = 1'b0; llc_drive(0); cycle();
        end
        clients('0, '0); bus.lc_ready_in = 1'b1; cycle();
        drain(10);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [N_CH-1:0] v, w;
            for (int c = 0; c < N_CH; c++) begin
                v[c] = ($urandom_range(99) < 60);
                w[c] = ($urandom_range(99) < 25);
            end
            clients(v, w);
            bus.lc_ready_in = ($urandom_range(99) < 70);
            for (int c = 0; c < N_CH; c++) bus.cl_ready_in[c] = ($urandom_range(99) < 70);
            llc_drive(60);
            cycle();
        end
        drain(40);
        chk("lc_sb_empty", LINE_W'(exp_lc_q.size()), '0);
        chk("cl_sb_empty", LINE_W'(exp_cl_q.size()), '0);

        // reset with a request held and reads outstanding
        for (int i = 0; i < 4; i++) begin
            clients('1, '0); bus.lc_ready_in = 1'b1; bus.lc_valid_in = 1'b0; cycle();
        end
        clients('1, '0); bus.lc_ready_in = 1'b0; cycle();
        rst_N_in = 1'b0;
        repeat (2) cycle();
        rst_N_in = 1'b1;
        clients('0, '0); bus.lc_ready_in = 1'b1; bus.lc_valid_in = 1'b0; cycle();
        // a posted write must not occupy the owner FIFO; the next response is an orphan
        clients(2'b01, 2'b01); cycle();
        clients('0, '0); repeat (2) cycle();
        bus.lc_valid_in = 1'b1; bus.lc_addr_in = 64'h0000_0000_0000_1000; cycle();
        bus.lc_valid_in = 1'b0; repeat (3) cycle();
        chk("orphan_sticky", LINE_W'(orphan_err_out), LINE_W'(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
